min_search_master: RTL and testbench
====================================

// Module: min_search_master
// PURPOSE
//  Bus initiator for the data_mem port (adr/d_in/mrd/mwr). On a start pulse it scans
//  N consecutive signed 32-bit words from BASE_ADR, tracks the minimum and its index,
//  and writes both back at RESULT_ADR / RESULT_ADR+4. It is the hardware counterpart
//  of the software min-search, sharing the same memory map and result layout.
// PARAMETERS
//  BASE_ADR    1000  byte address of element 0 (words little-endian, stride 4)
//  COUNT       20    number of elements scanned; legal range 1..65535
//  RESULT_ADR  2000  byte address of min value; min index goes to RESULT_ADR+4
// PORTS
//  clk        in   1   clock; all state changes on posedge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   request pulse; sampled only in IDLE
//  adr        out  32  byte address to data_mem
//  d_in       out  32  write data to data_mem
//  mrd        out  1   read enable to data_mem
//  mwr        out  1   write enable to data_mem (memory commits on posedge)
//  d_out      in   32  read data from data_mem (combinational, valid in the same cycle)
//  busy       out  1   high from the first READ cycle through WR_IDX
//  done       out  1   one-cycle pulse after both result words are written
//  min_value  out  32  last completed minimum (signed)
//  min_index  out  32  last completed index (0-based)
// BEHAVIOUR
//  - Reset: state=IDLE; adr, d_in, mrd, mwr, busy, done = 0; min_value, min_index = 0; counter i = 0.
//  - adr, d_in, mrd and mwr decode from registered state, i and the running min only.
//    There is no combinational path from start or d_out to any output.
//  - FSM states: IDLE -> READ -> WR_VAL -> WR_IDX -> DONE -> IDLE.
//  - IDLE: all bus outputs 0. start=1 -> READ with i=0.
//  - READ: mrd=1, adr=BASE_ADR+4*i. At the posedge, d_out is captured:
//      if i==0, or $signed(d_out) < $signed(cur_min), then cur_min=d_out and cur_idx=i.
//    Ties keep the earlier index (strict less-than).
//    i==COUNT-1 -> WR_VAL; otherwise i=i+1 and stay in READ.
//  - WR_VAL: mwr=1, mrd=0, adr=RESULT_ADR, d_in=cur_min.
//  - WR_IDX: mwr=1, adr=RESULT_ADR+4, d_in=cur_idx (zero-extended).
//    At the posedge, min_value and min_index are loaded from cur_min and cur_idx.
//  - DONE: done=1 for exactly one cycle, busy=0, bus idle; then IDLE.
//  - mrd and mwr are never high together. Address arithmetic is 32-bit wrapping with no checks.
//  - Latency: start sampled at edge 0. READ spans cycles 1..COUNT, WR_VAL is COUNT+1,
//    WR_IDX is COUNT+2, done is high in cycle COUNT+3.
//  - start while not in IDLE: ignored, not queued. start held high in DONE is also ignored.
//    start held high in IDLE re-triggers immediately.
//  - rst mid-operation: next cycle is IDLE with all outputs at reset values.
//    A write already committed at RESULT_ADR stays in memory; no further bus activity.
//  - min_value and min_index change only at the end of WR_IDX, so an aborted scan
//    leaves them at their reset value of 0.
// TESTING
//  1. Default array 12,13,21,31,44,53,19,2,-11,49,52,13,27,36,45,51,71,62,93,-84 at 1000;
//     pulse start -> mem[2000]=-84 (32'hFFFFFFAC), mem[2004]=19, done in cycle 23, busy 20+2 cycles.
//  2. Array with -7 at indices 3 and 11, all others positive
//     -> min_value=-7, min_index=3 (first occurrence wins).
//  3. COUNT=1, mem[1000]=5 -> one READ cycle; mem[2000]=5, mem[2004]=0; done in cycle 4.
//  4. Pulse start again in cycle 5 of a scan
//     -> ignored; exactly one done pulse; adr sequence 1000,1004,... is uninterrupted.
//  5. Assert rst during READ at i=7 -> IDLE next cycle; mrd=mwr=0; mem[2000]/mem[2004] untouched;
//     min_value=0; a fresh start then completes normally.
//  6. Protocol checker on every cycle: mrd&mwr never both 1; adr word-aligned whenever mrd|mwr;
//     done implies !busy.

Source files
------------

// File: rtl/min_search_master.sv
// Bus initiator that scans COUNT signed words from BASE_ADR, finds the minimum
// and its first index, and writes both back to RESULT_ADR / RESULT_ADR+4.
module min_search_master #(
  parameter logic [31:0] BASE_ADR   = 32'd1000,
  parameter int unsigned COUNT      = 20,
  parameter logic [31:0] RESULT_ADR = 32'd2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] adr,
  output logic [31:0] d_in,
  output logic        mrd,
  output logic        mwr,
  input  logic [31:0] d_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] min_value,
  output logic [31:0] min_index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WR_VAL,
    S_WR_IDX,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST = 16'(COUNT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_i;
  logic [15:0] r_cur_idx;
  logic [31:0] r_cur_min;
  logic [31:0] r_min_value;
  logic [31:0] r_min_index;
  logic        w_last;
  logic        w_take;

  assign w_last = (r_i == LAST);
  // Strict less-than keeps the earliest index on ties.
  assign w_take = (r_i == '0) || ($signed(d_out) < $signed(r_cur_min));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_READ;
      S_READ:   if (w_last) w_next = S_WR_VAL;
      S_WR_VAL: w_next = S_WR_IDX;
      S_WR_IDX: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i         <= '0;
      r_cur_idx   <= '0;
      r_cur_min   <= '0;
      r_min_value <= '0;
      r_min_index <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) r_i <= '0;
        S_READ: begin
          if (w_take) begin
            r_cur_min <= d_out;
            r_cur_idx <= r_i;
          end
          if (!w_last) r_i <= r_i + 16'd1;
        end
        S_WR_IDX: begin
          r_min_value <= r_cur_min;
          r_min_index <= {16'd0, r_cur_idx};
        end
        default: ;
      endcase
    end
  end

  // Bus outputs decode from registered state only.
  always_comb begin
    adr  = '0;
    d_in = '0;
    mrd  = 1'b0;
    mwr  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_READ: begin
        mrd  = 1'b1;
        busy = 1'b1;
        adr  = BASE_ADR + (32'(r_i) << 2);
      end
      S_WR_VAL: begin
        mwr  = 1'b1;
        busy = 1'b1;
        adr  = RESULT_ADR;
        d_in = r_cur_min;
      end
      S_WR_IDX: begin
        mwr  = 1'b1;
        busy = 1'b1;
        adr  = RESULT_ADR + 32'd4;
        d_in = {16'd0, r_cur_idx};
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign min_value = r_min_value;
  assign min_index = r_min_index;

endmodule

// File: tb/tb_min_search_master.sv
// Directed bench for min_search_master: a COUNT=20 instance and a COUNT=1 instance
// share one word memory; bus protocol invariants are checked every cycle.
module tb_min_search_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start20 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] adr20, d_in20, d_out20, minv20, mini20;
  logic        mrd20, mwr20, busy20, done20;
  logic [31:0] adr1, d_in1, d_out1, minv1, mini1;
  logic        mrd1, mwr1, busy1, done1;

  logic [31:0] mem [0:1023];
  logic        ld = 1'b0;
  logic [9:0]  ld_a = '0;
  logic [31:0] ld_d = '0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  min_search_master #(.BASE_ADR(32'd1000), .COUNT(20), .RESULT_ADR(32'd2000)) dut20 (
    .clk(clk), .rst(rst), .start(start20), .adr(adr20), .d_in(d_in20), .mrd(mrd20),
    .mwr(mwr20), .d_out(d_out20), .busy(busy20), .done(done20),
    .min_value(minv20), .min_index(mini20)
  );

  min_search_master #(.BASE_ADR(32'd1000), .COUNT(1), .RESULT_ADR(32'd2000)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .adr(adr1), .d_in(d_in1), .mrd(mrd1),
    .mwr(mwr1), .d_out(d_out1), .busy(busy1), .done(done1),
    .min_value(minv1), .min_index(mini1)
  );

  assign d_out20 = mem[adr20[11:2]];
  assign d_out1  = mem[adr1[11:2]];

  always @(posedge clk) begin
    if (ld) mem[ld_a] <= ld_d;
    else begin
      if (mwr20) mem[adr20[11:2]] <= d_in20;
      if (mwr1)  mem[adr1[11:2]]  <= d_in1;
    end
  end

  // Advance one cycle and check bus invariants on both instances.
  task automatic tick();
    @(posedge clk);
    #1;
    vecs++;
    if ((mrd20 & mwr20) !== 1'b0 || (mrd1 & mwr1) !== 1'b0) begin
      errs++; $display("FAIL proto_rdwr: mrd/mwr 20=%b%b 1=%b%b required not both 1", mrd20, mwr20, mrd1, mwr1);
    end
    vecs++;
    if (((mrd20 | mwr20) && adr20[1:0] !== 2'b00) || ((mrd1 | mwr1) && adr1[1:0] !== 2'b00)) begin
      errs++; $display("FAIL proto_align: adr20=%0d adr1=%0d required word aligned", adr20, adr1);
    end
    vecs++;
    if ((done20 & busy20) !== 1'b0 || (done1 & busy1) !== 1'b0) begin
      errs++; $display("FAIL proto_done_busy: done20/busy20=%b%b done1/busy1=%b%b required not both 1", done20, busy20, done1, busy1);
    end
  endtask

  task automatic load(input int unsigned wa, input logic [31:0] d);
    ld = 1'b1; ld_a = wa[9:0]; ld_d = d;
    tick();
    ld = 1'b0;
  endtask

  task automatic load_default();
    logic signed [31:0] v [20] = '{12, 13, 21, 31, 44, 53, 19, 2, -11, 49,
                                   52, 13, 27, 36, 45, 51, 71, 62, 93, -84};
    for (int k = 0; k < 20; k++) load(250 + k, v[k]);
  endtask

  task automatic pulse_start20();
    start20 = 1'b1;
    tick();
    start20 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    vecs++;
    if ({adr20, d_in20, mrd20, mwr20, busy20, done20, minv20, mini20} !== '0) begin
      errs++; $display("FAIL reset20: adr=%0d d_in=%0d mrd=%b mwr=%b busy=%b done=%b minv=%0d mini=%0d required all 0",
                       adr20, d_in20, mrd20, mwr20, busy20, done20, minv20, mini20);
    end
    vecs++;
    if ({adr1, d_in1, mrd1, mwr1, busy1, done1, minv1, mini1} !== '0) begin
      errs++; $display("FAIL reset1: adr=%0d mrd=%b mwr=%b busy=%b done=%b minv=%0d required all 0",
                       adr1, mrd1, mwr1, busy1, done1, minv1);
    end
  endtask

  task automatic test_default_scan();
    load_default();
    pulse_start20();
    for (int k = 0; k < 20; k++) begin
      vecs++;
      if ({mrd20, mwr20, busy20, adr20} !== {3'b101, 32'(1000 + 4 * k)}) begin
        errs++; $display("FAIL scan_read[%0d]: mrd/mwr/busy=%b%b%b adr=%0d required 101 adr=%0d",
                         k, mrd20, mwr20, busy20, adr20, 1000 + 4 * k);
      end
      tick();
    end
    vecs++;
    if ({mrd20, mwr20, busy20, adr20, d_in20} !== {3'b011, 32'd2000, 32'hFFFF_FFAC}) begin
      errs++; $display("FAIL scan_wr_val: mrd/mwr/busy=%b%b%b adr=%0d d_in=%h required 011 2000 ffffffac",
                       mrd20, mwr20, busy20, adr20, d_in20);
    end
    tick();
    vecs++;
    if ({mrd20, mwr20, busy20, adr20, d_in20} !== {3'b011, 32'd2004, 32'd19}) begin
      errs++; $display("FAIL scan_wr_idx: mrd/mwr/busy=%b%b%b adr=%0d d_in=%0d required 011 2004 19",
                       mrd20, mwr20, busy20, adr20, d_in20);
    end
    tick();
    vecs++;
    if ({done20, busy20, mrd20, mwr20, minv20, mini20} !== {4'b1000, 32'hFFFF_FFAC, 32'd19}) begin
      errs++; $display("FAIL scan_done: done/busy/mrd/mwr=%b%b%b%b minv=%h mini=%0d required 1000 ffffffac 19",
                       done20, busy20, mrd20, mwr20, minv20, mini20);
    end
    vecs++;
    if (mem[500] !== 32'hFFFF_FFAC || mem[501] !== 32'd19) begin
      errs++; $display("FAIL scan_mem: mem[2000]=%h mem[2004]=%0d required ffffffac 19", mem[500], mem[501]);
    end
    tick();
    vecs++;
    if ({done20, busy20, mrd20, mwr20} !== 4'b0000) begin
      errs++; $display("FAIL scan_after_done: done/busy/mrd/mwr=%b%b%b%b required 0000", done20, busy20, mrd20, mwr20);
    end
  endtask

  task automatic test_tie();
    logic signed [31:0] v [20] = '{5, 9, 3, -7, 8, 4, 6, 10, 2, 11,
                                   12, -7, 1, 14, 15, 16, 17, 18, 19, 20};
    for (int k = 0; k < 20; k++) load(250 + k, v[k]);
    pulse_start20();
    repeat (22) tick();
    vecs++;
    if ({done20, minv20, mini20} !== {1'b1, 32'hFFFF_FFF9, 32'd3}) begin
      errs++; $display("FAIL tie: done=%b minv=%0d mini=%0d required 1 -7 3", done20, $signed(minv20), mini20);
    end
    vecs++;
    if (mem[500] !== 32'hFFFF_FFF9 || mem[501] !== 32'd3) begin
      errs++; $display("FAIL tie_mem: mem[2000]=%h mem[2004]=%0d required fffffff9 3", mem[500], mem[501]);
    end
    tick();
  endtask

  task automatic test_count1();
    load(250, 32'd5);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    vecs++;
    if ({mrd1, mwr1, busy1, adr1} !== {3'b101, 32'd1000}) begin
      errs++; $display("FAIL c1_read: mrd/mwr/busy=%b%b%b adr=%0d required 101 1000", mrd1, mwr1, busy1, adr1);
    end
    tick();
    vecs++;
    if ({mrd1, mwr1, adr1, d_in1} !== {2'b01, 32'd2000, 32'd5}) begin
      errs++; $display("FAIL c1_wr_val: mrd/mwr=%b%b adr=%0d d_in=%0d required 01 2000 5", mrd1, mwr1, adr1, d_in1);
    end
    tick();
    vecs++;
    if ({mrd1, mwr1, adr1, d_in1} !== {2'b01, 32'd2004, 32'd0}) begin
      errs++; $display("FAIL c1_wr_idx: mrd/mwr=%b%b adr=%0d d_in=%0d required 01 2004 0", mrd1, mwr1, adr1, d_in1);
    end
    tick();
    vecs++;
    if ({done1, busy1, minv1, mini1} !== {2'b10, 32'd5, 32'd0} || mem[500] !== 32'd5 || mem[501] !== 32'd0) begin
      errs++; $display("FAIL c1_done: done/busy=%b%b minv=%0d mini=%0d mem=%0d,%0d required 10 5 0 5,0",
                       done1, busy1, minv1, mini1, mem[500], mem[501]);
    end
    tick();
    vecs++;
    if (done1 !== 1'b0) begin
      errs++; $display("FAIL c1_pulse: done=%b required 0", done1);
    end
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    load_default();
    pulse_start20();
    for (int c = 1; c <= 30; c++) begin
      if (c <= 20) begin
        vecs++;
        if ({mrd20, adr20} !== {1'b1, 32'(1000 + 4 * (c - 1))}) begin
          errs++; $display("FAIL ign_adr[%0d]: mrd=%b adr=%0d required 1 %0d", c, mrd20, adr20, 1000 + 4 * (c - 1));
        end
      end
      if (done20) ndone++;
      if (c > 23) begin
        vecs++;
        if ({mrd20, mwr20, busy20} !== 3'b000) begin
          errs++; $display("FAIL ign_idle[%0d]: mrd/mwr/busy=%b%b%b required 000", c, mrd20, mwr20, busy20);
        end
      end
      start20 = (c == 5);
      tick();
    end
    start20 = 1'b0;
    vecs++;
    if (ndone !== 1 || minv20 !== 32'hFFFF_FFAC) begin
      errs++; $display("FAIL ign_done: done pulses=%0d minv=%h required 1 ffffffac", ndone, minv20);
    end
  endtask

  task automatic test_rst_abort();
    load(500, 32'hDEAD_BEEF);
    load(501, 32'h0000_1234);
    pulse_start20();
    repeat (7) tick();
    vecs++;
    if ({mrd20, adr20} !== {1'b1, 32'd1028}) begin
      errs++; $display("FAIL abort_pre: mrd=%b adr=%0d required 1 1028", mrd20, adr20);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if ({mrd20, mwr20, busy20, done20, adr20, minv20, mini20} !== '0) begin
      errs++; $display("FAIL abort_idle: mrd/mwr/busy/done=%b%b%b%b adr=%0d minv=%0d mini=%0d required all 0",
                       mrd20, mwr20, busy20, done20, adr20, minv20, mini20);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      vecs++;
      if ({mrd20, mwr20, busy20} !== 3'b000) begin
        errs++; $display("FAIL abort_quiet[%0d]: mrd/mwr/busy=%b%b%b required 000", c, mrd20, mwr20, busy20);
      end
    end
    vecs++;
    if (mem[500] !== 32'hDEAD_BEEF || mem[501] !== 32'h0000_1234) begin
      errs++; $display("FAIL abort_mem: mem[2000]=%h mem[2004]=%h required deadbeef 00001234", mem[500], mem[501]);
    end
    pulse_start20();
    repeat (22) tick();
    vecs++;
    if ({done20, minv20, mini20} !== {1'b1, 32'hFFFF_FFAC, 32'd19} || mem[500] !== 32'hFFFF_FFAC || mem[501] !== 32'd19) begin
      errs++; $display("FAIL abort_rerun: done=%b minv=%h mini=%0d mem=%h,%0d required 1 ffffffac 19",
                       done20, minv20, mini20, mem[500], mem[501]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start20 = 1'b1;
    tick();
    repeat (22) tick();
    vecs++;
    if ({done20, busy20} !== 2'b10) begin
      errs++; $display("FAIL b2b_done1: done/busy=%b%b required 10", done20, busy20);
    end
    tick();
    vecs++;
    if ({done20, busy20, mrd20} !== 3'b000) begin
      errs++; $display("FAIL b2b_idle: done/busy/mrd=%b%b%b required 000", done20, busy20, mrd20);
    end
    tick();
    start20 = 1'b0;
    vecs++;
    if ({mrd20, busy20, adr20} !== {2'b11, 32'd1000}) begin
      errs++; $display("FAIL b2b_restart: mrd/busy=%b%b adr=%0d required 11 1000", mrd20, busy20, adr20);
    end
    repeat (22) tick();
    vecs++;
    if ({done20, minv20, mini20} !== {1'b1, 32'hFFFF_FFAC, 32'd19}) begin
      errs++; $display("FAIL b2b_done2: done=%b minv=%h mini=%0d required 1 ffffffac 19", done20, minv20, mini20);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_default_scan();
    test_tie();
    test_count1();
    test_start_ignored();
    test_rst_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
